// File: rtl/store_buffer.sv
// Purpose : in-order buffer of committed stores draining to dmem, with byte-granular load forwarding.
// Latency : a push is presented to dmem the cycle after it is accepted; forwarding is combinational.
// Backpres: store_buffer_full (registered count only) stalls upstream; dmem_resp paces the drain.
//
// Ports:
//   clk, rst                  clock / asynchronous active-low reset
//   sb_push*                  retiring store: address, lane mask, lane-aligned data
//   store_buffer_full/empty   occupancy flags derived from the registered count
//   dmem_addr/wmask/wdata     one outstanding write, held until dmem_resp; all zero when idle
//   dmem_resp                 single-cycle write-complete pulse
//   ld_addr, ld_fwd_*         load-address probe and merged forwarded bytes
module store_buffer #(
    parameter  int SB_DEPTH    = 2,
    localparam int SB_NUM_ELEM = 2 ** SB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sb_push,
    input  logic [31:0] sb_push_addr,
    input  logic [3:0]  sb_push_wmask,
    input  logic [31:0] sb_push_wdata,
    output logic        store_buffer_full,
    output logic        store_buffer_empty,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp,
    input  logic [31:0] ld_addr,
    output logic [3:0]  ld_fwd_mask,
    output logic [31:0] ld_fwd_data
);

    typedef struct packed {
        logic [29:0] word;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } sb_entry_t;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [SB_DEPTH:0] FULL_CNT = (SB_DEPTH + 1)'(SB_NUM_ELEM);

    sb_entry_t                 entries [SB_NUM_ELEM];
    logic [SB_NUM_ELEM-1:0]    valid;
    logic [SB_DEPTH-1:0]       head;
    logic [SB_DEPTH-1:0]       tail;
    logic [SB_DEPTH:0]         count;
    logic [SB_DEPTH:0]         count_nxt;
    state_t                    state;
    state_t                    state_nxt;
    logic                      push;
    logic                      pop;

    assign store_buffer_full  = (count == FULL_CNT);
    assign store_buffer_empty = (count == '0);

    assign push = sb_push && !store_buffer_full;
    // A response only retires an entry while a request is actually on the bus.
    assign pop  = (state == BUSY) && dmem_resp;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Entry payload needs no reset: it is only observed through valid bits or the BUSY state.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[head] <= '{word: sb_push_addr[31:2], wmask: sb_push_wmask, wdata: sb_push_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b1;
            end
            if (pop) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b0;
            end
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM: next state. Leaving IDLE looks at the incoming push too, so a
    // store accepted this cycle is on the bus the very next cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (count_nxt != '0) state_nxt = BUSY;
            BUSY: if (pop && count_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        dmem_addr  = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        if (state == BUSY) begin
            dmem_addr  = {entries[tail].word, 2'b00};
            dmem_wmask = entries[tail].wmask;
            dmem_wdata = entries[tail].wdata;
        end
    end

    // Forwarding: walk entries oldest to youngest so later stores overwrite
    // earlier ones lane by lane. The entry retiring this cycle is still valid here.
    always_comb begin
        logic [SB_DEPTH-1:0] idx;
        ld_fwd_mask = '0;
        ld_fwd_data = '0;
        idx         = '0;
        for (int i = 0; i < SB_NUM_ELEM; i++) begin
            idx = tail + SB_DEPTH'(i);
            if (valid[idx] && entries[idx].word == ld_addr[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[idx].wmask[b]) begin
                        ld_fwd_mask[b]         = 1'b1;
                        ld_fwd_data[8*b +: 8]  = entries[idx].wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
